// File: rtl/vga_timing.sv
// vga_timing: 640x480@60 raster counters, sync windows and blanked colour pins from one register stage.
module vga_timing #(
  parameter int PIX_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       red_ch,
  input  logic       green_ch,
  input  logic       blue_ch,
  output logic [9:0] x_crd,
  output logic [9:0] y_crd,
  output logic       pix_en,
  output logic       video_on,
  output logic       frame_tick,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic       vga_r,
  output logic       vga_g,
  output logic       vga_b
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [3:0]  DIV_LAST = 4'(PIX_DIV - 1);
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0]  HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0]  VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);

  logic [3:0] div_q, div_d;
  logic       pix_en_q, pix_en_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic       frame_tick_q, frame_tick_d;
  logic       hsync_q, hsync_d, vsync_q, vsync_d;
  logic       r_q, r_d, g_q, g_d, b_q, b_d;
  logic       x_wrap, y_wrap, von, in_hs, in_vs;

  always_comb begin
    x_wrap       = x_q == H_LAST;
    y_wrap       = y_q == V_LAST;
    von          = ({1'b0, x_q} < H_VIS) && ({1'b0, y_q} < V_VIS);
    in_hs        = (x_q >= HS_FIRST) && (x_q <= HS_LAST);
    in_vs        = (y_q >= VS_FIRST) && (y_q <= VS_LAST);
    div_d        = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
    pix_en_d     = div_q == DIV_LAST;
    x_d          = pix_en_q ? (x_wrap ? 10'd0 : x_q + 10'd1) : x_q;
    y_d          = (pix_en_q && x_wrap) ? (y_wrap ? 10'd0 : y_q + 10'd1) : y_q;
    frame_tick_d = pix_en_q && x_wrap && y_wrap;
    // pins sample the pixel the renderer answered for during this tick
    hsync_d      = pix_en_q ? (in_hs ? SYNC_POL : ~SYNC_POL) : hsync_q;
    vsync_d      = pix_en_q ? (in_vs ? SYNC_POL : ~SYNC_POL) : vsync_q;
    r_d          = pix_en_q ? (red_ch & von) : r_q;
    g_d          = pix_en_q ? (green_ch & von) : g_q;
    b_d          = pix_en_q ? (blue_ch & von) : b_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q        <= '0;
      pix_en_q     <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      frame_tick_q <= 1'b0;
      hsync_q      <= ~SYNC_POL;
      vsync_q      <= ~SYNC_POL;
      r_q          <= 1'b0;
      g_q          <= 1'b0;
      b_q          <= 1'b0;
    end else begin
      div_q        <= div_d;
      pix_en_q     <= pix_en_d;
      x_q          <= x_d;
      y_q          <= y_d;
      frame_tick_q <= frame_tick_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      r_q          <= r_d;
      g_q          <= g_d;
      b_q          <= b_d;
    end
  end

  assign x_crd      = x_q;
  assign y_crd      = y_q;
  assign pix_en     = pix_en_q;
  assign video_on   = von;
  assign frame_tick = frame_tick_q;
  assign vga_hsync  = hsync_q;
  assign vga_vsync  = vsync_q;
  assign vga_r      = r_q;
  assign vga_g      = g_q;
  assign vga_b      = b_q;
endmodule

// File: doc/vga_timing.md
# vga_timing

Raster timing generator and colour output stage for the 640x480@60 Hz VGA display. It produces the pixel coordinates `x_crd`/`y_crd` that the game renderer consumes, and takes back the renderer's combinational `red_ch`/`green_ch`/`blue_ch`. It blanks and registers those colour bits, then drives the monitor sync and colour pins from a single register stage, so all pin outputs stay mutually aligned.

## Interface
- `PIX_DIV`, 4: system clocks per pixel; 100 MHz / 4 = 25 MHz pixel rate. Legal range 1..16.
- `H_VISIBLE`, 640: visible pixels per line.
- `H_FRONT`, 16; `H_SYNC`, 96; `H_BACK`, 48: horizontal porch and sync widths, in pixels.
- `V_VISIBLE`, 480: visible lines per frame.
- `V_FRONT`, 10; `V_SYNC`, 2; `V_BACK`, 33: vertical porch and sync widths, in lines.
- `SYNC_POL`, 0: sync active level; 0 means active-low.

- `clk` input 1: system clock. One clock domain only.
- `rst_n` input 1: asynchronous, active-low reset.
- `red_ch`, `green_ch`, `blue_ch` input 1 each: renderer colour for the current `x_crd`/`y_crd`.
- `x_crd` output 10: current pixel column, 0..H_TOTAL-1.
- `y_crd` output 10: current line, 0..V_TOTAL-1.
- `pix_en` output 1: one-`clk` pixel strobe.
- `video_on` output 1: current coordinates lie in the visible area.
- `frame_tick` output 1: one-`clk` pulse at the start of each frame.
- `vga_hsync`, `vga_vsync` output 1 each: sync pins.
- `vga_r`, `vga_g`, `vga_b` output 1 each: colour pins.

## Operation
- H_TOTAL = sum of the four H parameters = 800. V_TOTAL = sum of the four V parameters = 525. Both must be ≤1024, because all counters are 10-bit unsigned.

**Pixel divider**
- `div_cnt` counts 0..PIX_DIV-1 and wraps.
- `pix_en` is registered. It is 1 for exactly the `clk` cycle following each edge on which `div_cnt` wraps to 0.
- With PIX_DIV=1, `pix_en` is constantly 1 from the first edge after reset release.

**Counters**
- `x_crd` and `y_crd` are driven directly from the counter registers.
- They update only on edges where `pix_en`=1.
- `x_crd` increments each step. At H_TOTAL-1 it wraps to 0 and `y_crd` increments.
- `y_crd` wraps to 0 when `x_crd` wraps while `y_crd` = V_TOTAL-1.

**Derived signals**
- `video_on` is combinational: (`x_crd` < H_VISIBLE) && (`y_crd` < V_VISIBLE).
- Horizontal sync window: `x_crd` in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. [656, 751].
- Vertical sync window: `y_crd` in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], i.e. [490, 491].

**Output stage**
- Registered; loads only on edges where `pix_en`=1.
- `vga_hsync` is loaded with the sync level when in the horizontal window (SYNC_POL), otherwise ~SYNC_POL.
- `vga_vsync` is loaded the same way from the vertical window.
- `vga_r` is loaded with `red_ch` & `video_on`; `vga_g` and `vga_b` are loaded the same way.
- Colour is therefore forced to 0 throughout horizontal and vertical blanking, whatever the renderer drives.

**frame_tick**
- Registered.
- It is 1 for the single `clk` cycle after the edge on which the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0, 0).
- It is not asserted at reset release.

**Reset (asynchronous)**
- `div_cnt`=0, `x_crd`=0, `y_crd`=0, `pix_en`=0, `frame_tick`=0.
- `vga_hsync` = `vga_vsync` = ~SYNC_POL, i.e. 1.
- `vga_r` = `vga_g` = `vga_b` = 0.
- `video_on` reads 1, because it is combinational on (0, 0).
- Asserting reset mid-frame forces these values immediately. After release the first frame restarts at (0, 0) with no `frame_tick`.

## Timing
- First `pix_en` is high in the cycle after the PIX_DIV-th rising edge following reset release.
- Pixel period = PIX_DIV `clk`. Line period = 800·PIX_DIV `clk` = 3200. Frame period = 420000·PIX_DIV `clk` = 1,680,000.
- Renderer path: the counters present (x, y); the renderer answers combinationally within the same pixel period; the pins show that pixel's colour on the next `pix_en` edge.
- Pin latency is therefore exactly one pixel tick after the coordinates, and the same for sync and colour, so they stay aligned with each other.
- Horizontal sync is asserted for H_SYNC·PIX_DIV = 384 `clk` per line. Vertical sync is asserted for 2 lines = 1600 pixel ticks.
- No handshake and no backpressure. The renderer must settle within PIX_DIV `clk` periods.

## Test plan
- **Reset:** hold `rst_n`=0 for 10 `clk`, with colour inputs at 1. Expect `x_crd`=0, `y_crd`=0, sync pins=1, colour pins=0, `pix_en`=0. After release, the first `pix_en` appears 4 `clk` later and the following `pix_en` 4 `clk` after that.
- **Horizontal timing:** run 2 lines. `vga_hsync` goes low one pixel tick after `x_crd`=656 and stays low for exactly 384 `clk`. Falling-edge period is 3200 `clk`.
- **Vertical timing and frame_tick:** run 2 frames. `vga_vsync` is low for 1600 pixel ticks, starting one tick after (0, 490). `frame_tick` pulses are 1 `clk` wide and 1,680,000 `clk` apart.
- **Blanking:** drive `red_ch`=1 constantly. `vga_r`=1 exactly for pixel ticks following `x_crd`<640 && `y_crd`<480. `vga_r`=0 at `x_crd`=640..799 and on lines 480..524.
- **Mid-frame reset:** assert `rst_n` at (300, 200) between `pix_en` pulses. Outputs reach reset values asynchronously. After release the counters restart at (0, 0), and no `frame_tick` occurs until a full frame has elapsed.
- **PIX_DIV=1 build:** `pix_en` stays at 1. Line period is 800 `clk`. Pins lag the coordinates by 1 `clk`.
